// File: rtl/pes_vm_pkg.sv
// -----------------------------------------------------------------------------
// pes_vm_pkg
// Shared types and constants for the vending machine (pes_vm).
//   pes_vm_state_e : credit state (S0 = no credit, S5 = 5 units, S10 = 10 units)
//   COIN_*         : encodings of the 2-bit coin input
//   CHG_*          : encodings of the 2-bit change output
// The product price is fixed at 15 units.
// -----------------------------------------------------------------------------
package pes_vm_pkg;

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2
  } pes_vm_state_e;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

endpackage : pes_vm_pkg

// File: rtl/pes_vm.sv
// -----------------------------------------------------------------------------
// pes_vm
// Coin-operated vending machine, price 15 units, accepting 5 and 10 coins.
// Credit is held in a three-state machine (S0/S5/S10); any payment that
// reaches or exceeds 15 dispenses and returns the excess as change, so the
// stored credit never exceeds 10.
//
// Ports
//   clock     : single clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset (0 clears state and outputs)
//   in[1:0]   : coin code sampled every rising edge
//               00 none, 01 = 5, 10 = 10, 11 = cancel/invalid
//   out       : registered one-cycle dispense pulse
//   change    : registered one-cycle change code, 00 none, 01 = 5, 10 = 10
//   state_dbg : current credit state, for observation only
//
// Coin interface: there is no handshake. Every rising edge at which `in`
// carries a valid coin code counts as one inserted coin, so a code held for
// N edges is N coins. Outputs reflect the coin sampled at the previous edge.
//
// Configuration
//   PES_VM_REFUND_EN : when defined, in=11 cancels the transaction and refunds
//                      the held credit through `change`. When undefined, in=11
//                      is ignored and no refund logic exists.
// -----------------------------------------------------------------------------
module pes_vm
  import pes_vm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    in,
  output logic          out,
  output logic [1:0]    change,
  output pes_vm_state_e state_dbg
);

  pes_vm_state_e state_q, state_d;
  logic          out_q, out_d;
  logic [1:0]    change_q, change_d;

  // Next-state and next-output logic. The outputs computed here are for the
  // coin being sampled at this edge; they are registered so they appear in
  // the following cycle and drop back to idle unless the next coin also
  // completes a sale.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = CHG_NONE;

    case (in)
      COIN_NONE: begin
        state_d = state_q;
      end

      COIN_5: begin
        case (state_q)
          S0:  state_d = S5;
          S5:  state_d = S10;
          S10: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          default: state_d = S0;
        endcase
      end

      COIN_10: begin
        case (state_q)
          S0:  state_d = S10;
          S5: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          S10: begin
            // 20 paid for a 15 item: dispense and hand back 5.
            state_d  = S0;
            out_d    = 1'b1;
            change_d = CHG_5;
          end
          default: state_d = S0;
        endcase
      end

      COIN_CANCEL: begin
`ifdef PES_VM_REFUND_EN
        // Cancel returns whatever credit was held; nothing is dispensed.
        state_d = S0;
        case (state_q)
          S5:      change_d = CHG_5;
          S10:     change_d = CHG_10;
          default: change_d = CHG_NONE;
        endcase
`else
        // Cancel/invalid code is ignored: credit is held.
        state_d = state_q;
`endif
      end

      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S0;
      out_q    <= 1'b0;
      change_q <= CHG_NONE;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign out       = out_q;
  assign change    = change_q;
  assign state_dbg = state_q;

endmodule : pes_vm

// File: tb/tb_pes_vm.sv
// -----------------------------------------------------------------------------
// tb_pes_vm
// Directed bench for pes_vm. Each step drives one coin code, waits for the
// rising edge and checks out/change/state 1 time unit later. Expected values
// are hand-computed from the price table (15 units, coins 5/10).
// Define PES_VM_REFUND_EN for both bench and RTL to exercise the refund build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pes_vm;
  import pes_vm_pkg::*;

  logic          clock;
  logic          reset;
  logic [1:0]    in;
  logic          out;
  logic [1:0]    change;
  pes_vm_state_e state_dbg;

  int checks   = 0;
  int failures = 0;

  pes_vm dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .change    (change),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all three observable values at once.
  task automatic check_all(input string tag, input logic e_out,
                           input logic [1:0] e_chg, input logic [1:0] e_st);
    check({tag, ".out"},    {3'b000, out},          {3'b000, e_out});
    check({tag, ".change"}, {2'b00, change},        {2'b00, e_chg});
    check({tag, ".state"},  {2'b00, 2'(state_dbg)}, {2'b00, e_st});
  endtask

  // ---------------- driver ----------------
  // Drive a coin code, let one rising edge sample it, look 1 unit later.
  task automatic step(input logic [1:0] coin);
    in = coin;
    @(posedge clock);
    #1;
  endtask

  // Pulse reset low away from any clock edge and check the async clear.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    check_all(tag, 1'b0, 2'b00, 2'd0);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    in    = 2'b00;

    // Reset held low while coins toggle: nothing moves.
    step(2'b01); check_all("rst_hold_c5",  1'b0, 2'b00, 2'd0);
    step(2'b10); check_all("rst_hold_c10", 1'b0, 2'b00, 2'd0);
    step(2'b11); check_all("rst_hold_c11", 1'b0, 2'b00, 2'd0);
    #3 reset = 1'b1; // deassert mid-cycle

    // Three 5-coins: 5, 10, then 15 dispenses exactly.
    step(2'b01); check_all("c5x3_e1",  1'b0, 2'b00, 2'd1);
    step(2'b01); check_all("c5x3_e2",  1'b0, 2'b00, 2'd2);
    step(2'b01); check_all("c5x3_e3",  1'b1, 2'b00, 2'd0);
    step(2'b00); check_all("c5x3_idle", 1'b0, 2'b00, 2'd0);

    // 5 then 10: exact payment.
    step(2'b01); check_all("c5c10_e1", 1'b0, 2'b00, 2'd1);
    step(2'b10); check_all("c5c10_e2", 1'b1, 2'b00, 2'd0);
    step(2'b00); check_all("c5c10_idle", 1'b0, 2'b00, 2'd0);

    // 10 then 10: overpay, change 5; then idle clears the pulse.
    step(2'b10); check_all("c10x2_e1", 1'b0, 2'b00, 2'd2);
    step(2'b10); check_all("c10x2_e2", 1'b1, 2'b01, 2'd0);
    step(2'b00); check_all("c10x2_idle", 1'b0, 2'b00, 2'd0);

    // Idle holds credit.
    step(2'b01); check_all("hold_e1", 1'b0, 2'b00, 2'd1);
    step(2'b00); check_all("hold_e2", 1'b0, 2'b00, 2'd1);
    step(2'b00); check_all("hold_e3", 1'b0, 2'b00, 2'd1);
    step(2'b10); check_all("hold_sale", 1'b1, 2'b00, 2'd0);

    // Back-to-back: sale, then the very next coin starts a new credit.
    step(2'b10); check_all("b2b_e1", 1'b0, 2'b00, 2'd2);
    step(2'b10); check_all("b2b_e2", 1'b1, 2'b01, 2'd0);
    step(2'b10); check_all("b2b_e3", 1'b0, 2'b00, 2'd2);
    step(2'b10); check_all("b2b_e4", 1'b1, 2'b01, 2'd0);
    step(2'b01); check_all("b2b_e5", 1'b0, 2'b00, 2'd1);
    step(2'b10); check_all("b2b_e6", 1'b1, 2'b00, 2'd0);
    // Two sales on consecutive edges: S10 + 5, then S5... need credit first.
    step(2'b10); check_all("b2b_e7", 1'b0, 2'b00, 2'd2);
    step(2'b01); check_all("b2b_e8", 1'b1, 2'b00, 2'd0);
    step(2'b00); check_all("b2b_idle", 1'b0, 2'b00, 2'd0);

    // Cancel from S0: no refund in either build.
    step(2'b11); check_all("cancel_s0", 1'b0, 2'b00, 2'd0);

    // Cancel from S10.
    step(2'b10); check_all("cancel_s10_pre", 1'b0, 2'b00, 2'd2);
    step(2'b11);
`ifdef PES_VM_REFUND_EN
    check_all("cancel_s10", 1'b0, 2'b10, 2'd0);
`else
    check_all("cancel_s10", 1'b0, 2'b00, 2'd2);
`endif
    async_reset("cancel_s10_rst");

    // Cancel from S5.
    step(2'b01); check_all("cancel_s5_pre", 1'b0, 2'b00, 2'd1);
    step(2'b11);
`ifdef PES_VM_REFUND_EN
    check_all("cancel_s5", 1'b0, 2'b01, 2'd0);
`else
    check_all("cancel_s5", 1'b0, 2'b00, 2'd1);
`endif
    async_reset("cancel_s5_rst");

    // Reset mid-transaction discards credit; the next coin counts from S0.
    step(2'b10); check_all("midrst_pre", 1'b0, 2'b00, 2'd2);
    async_reset("midrst_async");
    step(2'b01); check_all("midrst_post", 1'b0, 2'b00, 2'd1);
    step(2'b00); check_all("midrst_idle", 1'b0, 2'b00, 2'd1);

    // Reset while a dispense pulse is showing clears it immediately.
    step(2'b10); check_all("pulse_rst_e1", 1'b1, 2'b00, 2'd0);
    step(2'b10); check_all("pulse_rst_e2", 1'b0, 2'b00, 2'd2);
    step(2'b10); check_all("pulse_rst_e3", 1'b1, 2'b01, 2'd0);
    async_reset("pulse_rst_async");

    // Coin on the first edge after deassertion counts.
    reset = 1'b0;
    #2 reset = 1'b1;
    step(2'b10); check_all("deassert_coin", 1'b0, 2'b00, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pes_vm

// File: doc/pes_vm.md
PES_VM -- requirements
Module: pes_vm

Interface
REQ-001 The block SHALL have no parameters; the price is 15 units and coins are 5 or 10 units.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) clears the block immediately, independent of clock.
REQ-004 in  input  2  coin code sampled each rising edge: 2'b00 none, 2'b01 = 5, 2'b10 = 10, 2'b11 = cancel/invalid.
REQ-005 out  output  1  product dispensed, registered, one-cycle pulse.
REQ-006 change  output  2  change returned, registered, one-cycle: 2'b00 none, 2'b01 = 5, 2'b10 = 10.

Function
REQ-007 A three-state credit machine SHALL hold S0 (0 credit), S5 (5 credit) and S10 (10 credit).
REQ-008 A nonzero valid coin present at a rising edge SHALL count as one coin; a code held for N edges SHALL count N coins.
REQ-009 in=00 SHALL hold state; out=0, change=00.
REQ-010 S0: 01 -> S5; 10 -> S10; out=0, change=00.
REQ-011 S5: 01 -> S10, out=0; 10 -> S0, out=1, change=00.
REQ-012 S10: 01 -> S0, out=1, change=00; 10 -> S0, out=1, change=01.
REQ-013 out/change SHALL be registered and valid in the cycle after the completing coin's edge, lasting exactly one cycle unless the next coin also completes a sale.
REQ-014 Back-to-back sales SHALL be supported with no idle cycle; e.g. S10 + 10 then S0 + 10 gives out=1,change=01 then out=0.
REQ-015 in=11 without PES_VM_REFUND_EN SHALL be ignored: state held, out=0, change=00.
REQ-016 Credit SHALL never exceed 10 in the state register; overpayment SHALL be returned only via change.

Reset
REQ-017 While reset=0: state=S0, out=0, change=00, asynchronously.
REQ-018 Reset deassertion SHALL take effect at the next rising edge; coins on that edge SHALL count.
REQ-019 Reset mid-transaction SHALL discard credit without refund or dispense.

Configuration
REQ-020 Macro PES_VM_REFUND_EN: when defined, in=11 SHALL return to S0 with out=0 and change=01 from S5, change=10 from S10, change=00 from S0.
REQ-021 When PES_VM_REFUND_EN is undefined, REQ-015 SHALL apply and no refund logic SHALL be synthesized.

Structure
REQ-022 Package pes_vm_pkg SHALL hold the state enum (S0, S5, S10), coin code constants (COIN_NONE, COIN_5, COIN_10, COIN_CANCEL) and change constants (CHG_NONE, CHG_5, CHG_10).
REQ-023 Implementation SHALL be a single module: next-state/output combinational logic plus one registered process; no sub-module.

Verification
REQ-024 Reset held low, in toggled -> out=0, change=00, state S0 throughout.
REQ-025 After reset, in=01 for 3 edges -> out=1 pulse after 3rd edge, change=00, then S0.
REQ-026 in=01 one edge, then in=10 one edge -> out=1, change=00 after 2nd edge.
REQ-027 in=10 for 2 edges -> out=1, change=01 after 2nd edge; 3rd edge in=00 -> out=0.
REQ-028 in=10 one edge, reset pulsed low mid-cycle, then in=01 -> state S5, no out pulse.
REQ-029 With PES_VM_REFUND_EN: in=10 then in=11 -> out=0, change=10, state S0; without the macro -> change=00, state S10.
